uart_inst_loader: RTL and testbench

//  Parametrised instruction store filled over a UART serial line carrying ASCII hex text.

---
 rtl/uart_inst_loader_pkg.sv | 24 ++
 rtl/uart_inst_loader_if.sv | 10 +
 rtl/uart_inst_loader_rx_byte.sv | 80 ++++++++
 rtl/uart_inst_loader.sv | 107 ++++++++++
 tb/tb_uart_inst_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_inst_loader_pkg.sv
// rtl/uart_inst_loader_pkg.sv - receiver state type, ASCII hex bounds and hex decode helper
package inst_loader_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_F_LO = 8'h66;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_F_UP = 8'h46;

  // Returns {valid, nibble}; letters have low nibble 1..6, so +9 yields 10..15.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= CH_0 && c <= CH_9)
      r = {1'b1, c[3:0]};
    else if ((c >= CH_A_LO && c <= CH_F_LO) || (c >= CH_A_UP && c <= CH_F_UP))
      r = {1'b1, 4'(c[3:0] + 4'd9)};
    return r;
  endfunction

endpackage

// File: rtl/uart_inst_loader_if.sv
// rtl/uart_inst_loader_if.sv - fetch-side read port of the instruction store
interface uart_inst_loader_if #(
  parameter int WORD_W = 32
);
  logic [31:0]       pc;
  logic [WORD_W-1:0] inst;

  modport master (output pc, input inst);
  modport slave  (input pc, output inst);
endinterface

// File: rtl/uart_inst_loader_rx_byte.sv
// rtl/uart_inst_loader_rx_byte.sv - 8N1 UART byte receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
  import inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       txd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             txd_meta, txd_sync, txd_prev;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      {txd_meta, txd_sync, txd_prev} <= 3'b111;
    end else begin
      txd_meta <= txd;
      txd_sync <= txd_meta;
      txd_prev <= txd_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      IDLE:  if (txd_prev && !txd_sync) state_nxt = START;
      START: if (clk_cnt == HALF_LAST) state_nxt = txd_sync ? IDLE : DATA;
      DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          state_nxt       = IDLE;
          byte_valid      = txd_sync;
          frame_err_pulse = !txd_sync;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change, so the START->DATA hop lands it mid-bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || state_nxt != state || clk_cnt == BIT_LAST) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      if (state == IDLE) bit_idx <= '0;
      else if (state == DATA && clk_cnt == BIT_LAST) begin
        shreg   <= {txd_sync, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign byte_data = shreg;
  assign busy      = (state != IDLE);

endmodule

// File: rtl/uart_inst_loader.sv
// rtl/uart_inst_loader.sv - hex-over-UART instruction store loader
// Optional: INST_LOADER_CHECKSUM_EN adds a byte-sum checksum of written words.
module uart_inst_loader
  import inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int WORD_W       = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              txd,
  input  logic              ld_clr,
  uart_inst_loader_if.slave fetch,
  output logic [ADDR_W:0]   load_cnt,
  output logic              loaded,
  output logic              busy,
  output logic              frame_err,
  output logic              fmt_err
`ifdef INST_LOADER_CHECKSUM_EN
  , output logic [7:0]      checksum
`endif
);

  localparam int NIBS  = WORD_W / 4;
  localparam int NIB_W = $clog2(NIBS + 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBS - 1);
  localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(DEPTH);

  logic              byte_valid, frame_err_pulse, rx_busy;
  logic [7:0]        byte_data;
  logic [4:0]        hx;
  logic [NIB_W-1:0]  nib_cnt;
  logic [WORD_W-1:0] shreg, word_nxt;
  logic              word_done, do_write;
  logic [WORD_W-1:0] mem [DEPTH];

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .resetn          (resetn),
    .txd             (txd),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse),
    .busy            (rx_busy)
  );

  assign hx        = hex2nib(byte_data);
  assign word_nxt  = {shreg[WORD_W-5:0], hx[3:0]};
  assign word_done = byte_valid && hx[4] && (nib_cnt == NIB_LAST);
  assign do_write  = word_done && !loaded && !ld_clr;
  assign loaded    = (load_cnt == FULL);
  assign busy      = rx_busy || (nib_cnt != '0);

  always_ff @(posedge clk) begin
    if (do_write) mem[load_cnt[ADDR_W-1:0]] <= word_nxt;
  end

  assign fetch.inst = mem[fetch.pc[ADDR_W+1:2]];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch.pc[31:ADDR_W+2], fetch.pc[1:0]};

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] word_sum;
  always_comb begin
    word_sum = '0;
    for (int i = 0; i < WORD_W / 8; i++) word_sum = word_sum + word_nxt[i*8 +: 8];
    if (WORD_W % 8 != 0) word_sum = word_sum + 8'(word_nxt[WORD_W-1 -: 4]);
  end

  always_ff @(posedge clk) begin
    if (!resetn || ld_clr) checksum <= '0;
    else if (do_write)     checksum <= checksum + word_sum;
  end
`endif

  // ld_clr takes priority over everything, including a word completing on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn || ld_clr) begin
      nib_cnt   <= '0;
      load_cnt  <= '0;
      frame_err <= 1'b0;
      fmt_err   <= 1'b0;
      shreg     <= '0;
    end else begin
      if (frame_err_pulse) frame_err <= 1'b1;
      if (byte_valid) begin
        if (hx[4]) begin
          shreg <= word_nxt;
          if (nib_cnt == NIB_LAST) begin
            nib_cnt <= '0;
            if (!loaded) load_cnt <= load_cnt + 1'b1;
            else         fmt_err  <= 1'b1;
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end else if (nib_cnt != '0) begin
          nib_cnt <= '0;
          fmt_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// tb/tb_uart_inst_loader.sv - scoreboard bench for uart_inst_loader (CLKS_PER_BIT=16)
module tb_uart_inst_loader;

  localparam int CPB    = 16;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            txd = 1'b1;
  logic            ld_clr = 1'b0;
  logic [ADDR_W:0] load_cnt;
  logic            loaded, busy, frame_err, fmt_err;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]      checksum;
`endif

  uart_inst_loader_if #(.WORD_W(WORD_W)) fetch ();

  always #5 clk = ~clk;

  uart_inst_loader #(
    .CLKS_PER_BIT (CPB),
    .WORD_W       (WORD_W),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .txd       (txd),
    .ld_clr    (ld_clr),
    .fetch     (fetch),
    .load_cnt  (load_cnt),
    .loaded    (loaded),
    .busy      (busy),
    .frame_err (frame_err),
    .fmt_err   (fmt_err)
`ifdef INST_LOADER_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  typedef struct {
    int          slot;
    logic [31:0] word;
  } exp_t;

  exp_t wr_q[$];
  exp_t probe_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexchar(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h61 + 8'(n) - 8'd10;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    txd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txd = b[i];
      repeat (CPB) @(negedge clk);
    end
    txd = stop_bit;
    repeat (CPB) @(negedge clk);
    txd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_byte(hexchar(w[i*4 +: 4]));
  endtask

  task automatic pulse_clr();
    ld_clr = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every load_cnt step must match the next expected write; also serves read probes.
  initial begin : monitor
    logic [ADDR_W:0] prev_cnt;
    exp_t            e;
    prev_cnt = '0;
    fetch.pc = '0;
    forever begin
      @(negedge clk);
      if (resetn && load_cnt == prev_cnt + 1'b1) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_slot=%0d required=no write", prev_cnt);
        end else begin
          e = wr_q.pop_front();
          check("write_slot", 64'(prev_cnt), 64'(e.slot));
          fetch.pc = 32'hA5A0_0000 | (32'(e.slot) << 2) | 32'h3;
          #1;
          check("write_word", 64'(fetch.inst), 64'(e.word));
        end
      end
      prev_cnt = load_cnt;
      if (probe_q.size() > 0) begin
        e = probe_q.pop_front();
        fetch.pc = 32'h7F00_0000 | (32'(e.slot) << 2);
        #1;
        check("probe_word", 64'(fetch.inst), 64'(e.word));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] fill [DEPTH];

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_load_cnt", 64'(load_cnt), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_fmt_err", 64'(fmt_err), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check("rst_checksum", 64'(checksum), 64'd0);
`endif

    // Lowercase word followed by a separator.
    wr_q.push_back('{slot: 0, word: 32'h0123abcd});
    send_str("0123abcd\n");
    check("t1_load_cnt", 64'(load_cnt), 64'd1);
    check("t1_fmt_err", 64'(fmt_err), 64'd0);
    probe_q.push_back('{slot: 0, word: 32'h0123abcd});

    // Upper and lower case decode identically.
    wr_q.push_back('{slot: 1, word: 32'hdeadbeef});
    send_str("DEADBEEF");
    wr_q.push_back('{slot: 2, word: 32'hdeadbeef});
    send_str("deadbeef");
    check("t2_load_cnt", 64'(load_cnt), 64'd3);
    probe_q.push_back('{slot: 1, word: 32'hdeadbeef});

    // Illegal char mid-word; the trailing newline also discards the lone '4'.
    send_str("12g");
    check("t3_fmt_err", 64'(fmt_err), 64'd1);
    check("t3_no_write", 64'(load_cnt), 64'd3);
    send_str("4\n");
    check("t3_partial_dropped", 64'(busy), 64'd0);
    wr_q.push_back('{slot: 3, word: 32'h00000001});
    send_str("00000001");
    check("t3_next_slot", 64'(load_cnt), 64'd4);

    // Clear, fill every slot, then overflow by one.
    pulse_clr();
    check("t4_clr_load_cnt", 64'(load_cnt), 64'd0);
    check("t4_clr_fmt_err", 64'(fmt_err), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = {8'(i), 8'hc3, ~8'(i), 8'h3c};
      wr_q.push_back('{slot: i, word: fill[i]});
      send_word(fill[i]);
    end
    check("t4_loaded", 64'(loaded), 64'd1);
    check("t4_load_cnt_full", 64'(load_cnt), 64'(DEPTH));
    check("t4_fmt_err_before", 64'(fmt_err), 64'd0);
    send_str("ffffffff");
    check("t4_overflow_fmt_err", 64'(fmt_err), 64'd1);
    check("t4_no_wrap", 64'(load_cnt), 64'(DEPTH));
    probe_q.push_back('{slot: 0, word: 32'h00c3ff3c});
    probe_q.push_back('{slot: DEPTH - 1, word: 32'h1fc3e03c});

    // Stop bit held low, then a start glitch shorter than half a bit.
    pulse_clr();
    check("t5_clr_fmt_err", 64'(fmt_err), 64'd0);
    send_byte("5", 1'b0);
    check("t5_frame_err", 64'(frame_err), 64'd1);
    check("t5_byte_dropped", 64'(busy), 64'd0);
    txd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    txd = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_glitch_busy", 64'(busy), 64'd1);
    repeat (2 * CPB) @(negedge clk);
    check("t5_glitch_idle", 64'(busy), 64'd0);
    check("t5_glitch_no_load", 64'(load_cnt), 64'd0);

    // Reset in the middle of a byte.
    txd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    resetn = 1'b0;
    txd    = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_frame_err", 64'(frame_err), 64'd0);
    check("t6_rst_load_cnt", 64'(load_cnt), 64'd0);
    wr_q.push_back('{slot: 0, word: 32'hcafef00d});
    send_word(32'hcafef00d);
    check("t6_load_cnt", 64'(load_cnt), 64'd1);
`ifdef INST_LOADER_CHECKSUM_EN
    check("t6_checksum", 64'(checksum), 64'hc5);
    pulse_clr();
    check("ck_clr", 64'(checksum), 64'd0);
    wr_q.push_back('{slot: 0, word: 32'h01020304});
    send_str("01020304");
    check("ck_sum", 64'(checksum), 64'h0a);
`endif

    repeat (10) @(negedge clk);
    check("write_queue_drained", 64'(wr_q.size()), 64'd0);
    check("probe_queue_drained", 64'(probe_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
